lsu_ctrl: RTL and testbench

Load/store unit between the core's memory-access stage and the word-addressed data memory (`dmem`: 64×32-bit, asynchronous read, write on `posedge clk` when `memwrite`). It accepts byte-addressed RV32I load/store requests over a valid/ready handshake, converts them to word accesses, and handles sub-word stores by read-modify-write. It also sign- or zero-extends sub-word loads and flags misaligned, out-of-range and illegal accesses without touching memory.

---
 rtl/lsu_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit between the core memory stage and a word-addressed
// data memory (asynchronous read, write on the rising edge while mem_write=1).
// Byte-addressed RV32I loads and stores are converted to word accesses. Loads
// are lane-selected and sign/zero-extended. SB/SH use read-modify-write.
// Misaligned, out-of-range and illegal requests return resp_err without
// touching memory.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    request handshake; ready only while idle
//   req_we                 1 = store, 0 = load
//   req_funct3             RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr, req_wdata    byte address, right-aligned store data
//   resp_valid             one-cycle completion pulse
//   resp_rdata, resp_err   extended load data / error flag, held until next response
//   mem_address            word index {2'b0, addr[31:2]}
//   mem_write, mem_wdata   memory write strobe and data
//   mem_rdata              combinational memory read data
module lsu_ctrl #(
  parameter int DMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [29:0] DEPTH_W = 30'(DMEM_DEPTH);

  state_t      state, state_nxt;
  logic        accept;
  logic        req_err;

  // Request fields captured at accept
  logic        we_p0;
  logic [2:0]  funct3_p0;
  logic [1:0]  lane_p0;
  logic        err_p0;

  function automatic logic access_err(input logic        we,
                                      input logic [2:0]  f3,
                                      input logic [31:0] addr);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    illegal      = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
    misaligned   = ((f3[1:0] == 2'b01) && addr[0]) ||
                   ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    out_of_range = (addr[31:2] >= DEPTH_W);
    return illegal || misaligned || out_of_range;
  endfunction

  // Lane select plus extension; f3[2] selects zero-extension (LBU/LHU).
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'b0, b} : 32'(b);
      2'b01:   r = f3[2] ? {16'b0, h} : 32'(h);
      default: r = word;
    endcase
    return r;
  endfunction

  // Insert the store byte/halfword into the word read back from memory.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wdata[15:0];
    end else begin
      r[15:0] = wdata[15:0];
    end
    return r;
  endfunction

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_write  = (state == WRITE);
  assign accept     = req_valid && req_ready;
  assign req_err    = access_err(req_we, req_funct3, req_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Errored requests spend one dead cycle in READ so that every non-RMW
  // response lands at the same latency; nothing is sampled or written there.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!req_err && req_we && (req_funct3 == 3'b010)) state_nxt = WRITE;
          else                                             state_nxt = READ;
        end
      end
      READ: begin
        if (err_p0 || !we_p0) state_nxt = RESP;
        else                  state_nxt = WRITE;
      end
      WRITE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_p0       <= 1'b0;
      funct3_p0   <= 3'b000;
      lane_p0     <= 2'b00;
      err_p0      <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      // Stage 0: capture request; mem_wdata doubles as the captured store data
      if (accept) begin
        we_p0       <= req_we;
        funct3_p0   <= req_funct3;
        lane_p0     <= req_addr[1:0];
        err_p0      <= req_err;
        mem_address <= {2'b00, req_addr[31:2]};
        mem_wdata   <= req_wdata;
      end
      // Stage 1: read-modify-write merge for SB/SH
      if ((state == READ) && we_p0 && !err_p0) begin
        mem_wdata <= store_merge(mem_rdata, mem_wdata, funct3_p0[1:0], lane_p0);
      end
      // Stage 2: response registers update only when a response is produced
      if (state_nxt == RESP) begin
        resp_err   <= err_p0;
        resp_rdata <= ((state == READ) && !we_p0 && !err_p0)
                      ? load_extend(mem_rdata, funct3_p0, lane_p0) : '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_ctrl #(.DMEM_DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory plus a backdoor port for preloading
  logic [31:0] mem [64];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_data;

  assign mem_rdata = (mem_address < 32'd64) ? mem[mem_address[5:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && (mem_address < 32'd64)) mem[mem_address[5:0]] <= mem_wdata;
    if (bd_we) mem[bd_idx] <= bd_data;
  end

  // Reference memory image, updated by the model
  logic [31:0] ref_mem [64];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: byte-addressed access semantics on ref_mem.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
    int          size;
    int          sh;
    logic        legal;
    logic [31:0] idx;
    logic [31:0] mask;
    logic [31:0] word;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    idx   = addr / 4;
    err   = !legal || ((addr % size) != 0) || (idx >= 64);
    rdata = 32'h0;
    lat   = 2;
    if (!err) begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      sh   = 8 * int'(addr % 4);
      word = ref_mem[idx[5:0]];
      if (!we) begin
        rdata = (word >> sh) & mask;
        if (!f3[2] && (size < 4) && rdata[8*size-1]) rdata = rdata | ~mask;
      end else begin
        ref_mem[idx[5:0]] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
        if (size < 4) lat = 3;
      end
    end
  endtask

  // Issue one request and observe it to completion (bounded).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat, output int nwr,
                        output int wr_cyc, output logic [31:0] wr_addr, output logic ok);
    rdata = 32'h0; err = 1'b0; lat = 0; nwr = 0; wr_cyc = 0; wr_addr = 32'h0; ok = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 10 && !req_ready; w++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_write) begin nwr++; wr_cyc = c; wr_addr = mem_address; end
      if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; break; end
    end
    @(negedge clk);
    ok = !resp_valid && req_ready && (resp_rdata === rdata) && (resp_err === err);
  endtask

  task automatic run_vec(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [31:0] rdata, wr_addr, idx;
    logic        err, ok;
    int          lat, nwr, wr_cyc;
    do_req(we, f3, addr, wdata, rdata, err, lat, nwr, wr_cyc, wr_addr, ok);
    chk({tag, "_rdata"}, rdata, exp_rdata);
    chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_writes"}, 32'(nwr), (we && !exp_err) ? 32'd1 : 32'd0);
    if (nwr == 1) begin
      chk({tag, "_wr_cycle"}, 32'(wr_cyc), 32'(exp_lat - 1));
      chk({tag, "_wr_addr"}, wr_addr, addr >> 2);
    end
    chk({tag, "_pulse_hold"}, {31'b0, ok}, 32'd1);
    idx = addr >> 2;
    if (idx < 64) chk({tag, "_memword"}, mem[idx[5:0]], ref_mem[idx[5:0]]);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t tv [18];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mr;
    logic        me;
    int          ml;
    logic        saw;
    logic [2:0]  bb_f3 [3];
    logic [31:0] bb_addr [3];
    logic [31:0] bb_exp [3];
    int          acc [3];
    int          na, nr, cyc, lowcnt;
    logic        took;

    tv[0]  = '{1'b0, 3'd0, 32'h14,  32'h0,         32'hFFFF_FFFF, 1'b0, 2};
    tv[1]  = '{1'b0, 3'd4, 32'h15,  32'h0,         32'h0000_00F0, 1'b0, 2};
    tv[2]  = '{1'b0, 3'd1, 32'h16,  32'h0,         32'hFFFF_8070, 1'b0, 2};
    tv[3]  = '{1'b0, 3'd5, 32'h14,  32'h0,         32'h0000_F0FF, 1'b0, 2};
    tv[4]  = '{1'b0, 3'd2, 32'h14,  32'h0,         32'h8070_F0FF, 1'b0, 2};
    tv[5]  = '{1'b1, 3'd0, 32'h15,  32'h1234_56AB, 32'h0,         1'b0, 3};
    tv[6]  = '{1'b0, 3'd2, 32'h14,  32'h0,         32'h8070_ABFF, 1'b0, 2};
    tv[7]  = '{1'b1, 3'd1, 32'h16,  32'hCAFE_1234, 32'h0,         1'b0, 3};
    tv[8]  = '{1'b0, 3'd2, 32'h14,  32'h0,         32'h1234_ABFF, 1'b0, 2};
    tv[9]  = '{1'b1, 3'd2, 32'h00,  32'hDEAD_BEEF, 32'h0,         1'b0, 2};
    tv[10] = '{1'b0, 3'd2, 32'h00,  32'h0,         32'hDEAD_BEEF, 1'b0, 2};
    tv[11] = '{1'b0, 3'd1, 32'h03,  32'h0,         32'h0,         1'b1, 2};
    tv[12] = '{1'b1, 3'd2, 32'h02,  32'h1111_1111, 32'h0,         1'b1, 2};
    tv[13] = '{1'b0, 3'd2, 32'h100, 32'h0,         32'h0,         1'b1, 2};
    tv[14] = '{1'b0, 3'd3, 32'h00,  32'h0,         32'h0,         1'b1, 2};
    tv[15] = '{1'b1, 3'd4, 32'h04,  32'h5555_5555, 32'h0,         1'b1, 2};
    tv[16] = '{1'b0, 3'd0, 32'h03,  32'h0,         32'hFFFF_FFDE, 1'b0, 2};
    tv[17] = '{1'b0, 3'd5, 32'h02,  32'h0,         32'h0000_DEAD, 1'b0, 2};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; bd_we = 1'b0; bd_idx = 6'd0; bd_data = 32'h0;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 6'(i);
      bd_data = (i == 5) ? 32'h8070_F0FF : $urandom;
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_we = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      model(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, mr, me, ml);
      run_vec($sformatf("vec%0d", i), tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata,
              tv[i].exp_rdata, tv[i].exp_err, tv[i].exp_lat);
    end

    // Reset asserted during the WRITE cycle of SB @0x08
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h08; req_wdata = 32'h55;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_write_seen", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_write_drop", {31'b0, mem_write}, 32'd0);
    chk("abort_ready_in_rst", {31'b0, req_ready}, 32'd1);
    chk("abort_wdata_rst", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) saw = 1'b1;
    end
    chk("abort_no_resp", {31'b0, saw}, 32'd0);
    chk("abort_word2", mem[2], ref_mem[2]);
    chk("abort_ready_after", {31'b0, req_ready}, 32'd1);

    // req_valid held high across three loads
    bb_f3[0] = 3'd2; bb_addr[0] = 32'h14;
    bb_f3[1] = 3'd2; bb_addr[1] = 32'h00;
    bb_f3[2] = 3'd4; bb_addr[2] = 32'h15;
    for (int k = 0; k < 3; k++) begin
      model(1'b0, bb_f3[k], bb_addr[k], 32'h0, bb_exp[k], me, ml);
      acc[k] = 0;
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = bb_f3[0]; req_addr = bb_addr[0];
    na = 0; nr = 0; cyc = 0; lowcnt = 0;
    while (nr < 3 && cyc < 40) begin
      if (resp_valid) begin
        chk($sformatf("b2b_rdata%0d", nr), resp_rdata, bb_exp[nr]);
        nr++;
      end
      took = req_valid && req_ready;
      if (req_valid && !req_ready && na > 0 && na < 3) lowcnt++;
      if (took && na < 3) begin acc[na] = cyc; na++; end
      @(posedge clk);
      #1;
      if (took) begin
        if (na < 3) begin req_funct3 = bb_f3[na]; req_addr = bb_addr[na]; end
        else req_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b0;
    chk("b2b_responses", 32'(nr), 32'd3);
    chk("b2b_accepts", 32'(na), 32'd3);
    chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd3);
    chk("b2b_ready_low", 32'(lowcnt), 32'd4);

    // Randomized requests against the model
    for (int i = 0; i < 80; i++) begin
      logic        rwe;
      logic [2:0]  rf3;
      logic [31:0] raddr, rwd;
      rwe   = 1'($urandom);
      rf3   = 3'($urandom);
      if ($urandom_range(0, 9) == 0) raddr = $urandom;
      else raddr = 32'($urandom_range(0, 67)) * 4 + 32'($urandom_range(0, 3));
      rwd   = $urandom;
      model(rwe, rf3, raddr, rwd, mr, me, ml);
      run_vec($sformatf("rnd%0d", i), rwe, rf3, raddr, rwd, mr, me, ml);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
